// File: rtl/time_set_rx.sv
// -----------------------------------------------------------------------------
// time_set_rx
//
// Receives a time-set command over an 8N1 UART line and presents it as six
// BCD digits. A command is 'T', six ASCII digits "hhmmss", then CR. Digits
// are collected in shadow registers and copied to the outputs only when the
// terminating CR arrives, so the outputs always show a complete, valid time.
//
// Parameters
//   CLK_HZ      clock frequency in Hz
//   BAUD        serial bit rate; one bit lasts CLK_HZ/BAUD clock cycles
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   rxd         asynchronous UART line, idle high, LSB first
//   load        one-cycle pulse: the BCD outputs now hold a new time
//   hour_upper .. sec_lower   BCD time digits
//   err         one-cycle pulse on framing error or bad command byte
//   busy        high while a UART frame is being received
// -----------------------------------------------------------------------------
module time_set_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       load,
    output logic [3:0] hour_upper,
    output logic [3:0] hour_lower,
    output logic [3:0] min_upper,
    output logic [3:0] min_lower,
    output logic [3:0] sec_upper,
    output logic [3:0] sec_lower,
    output logic       err,
    output logic       busy
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int HALF  = DIV / 2;
    // The bit timer only ever counts up to DIV-1.
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(DIV - 1);

    localparam logic [7:0] CH_T  = 8'h54;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        P_WAIT_T  = 3'd0,
        P_D0      = 3'd1,
        P_D1      = 3'd2,
        P_D2      = 3'd3,
        P_D3      = 3'd4,
        P_D4      = 3'd5,
        P_D5      = 3'd6,
        P_WAIT_CR = 3'd7
    } p_state_t;

    // ------------------------------------------------------------------
    // Input synchronizer and falling-edge detector
    // ------------------------------------------------------------------
    logic [1:0] rx_sync_q;
    logic       rx_prev_q;
    logic       rx_bit;
    logic       rx_fall;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, which is what makes the
    // synchronizer a true two-stage shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rxd};
            rx_prev_q <= rx_sync_q[1];
        end
    end

    assign rx_bit  = rx_sync_q[1];
    assign rx_fall = rx_prev_q & ~rx_bit;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t        rx_state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       rx_data_q;
    logic             busy_q;

    logic bit_end;
    logic byte_done;
    logic frame_err;

    assign bit_end   = (bit_cnt_q == CNT_BIT_END);
    // The stop-bit sample decides the frame; the parser reacts on the same
    // edge so load/err appear in the cycle right after the sample.
    assign byte_done = (rx_state_q == RX_STOP) && bit_end &&  rx_bit;
    assign frame_err = (rx_state_q == RX_STOP) && bit_end && !rx_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            rx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state_q <= RX_START;
                        bit_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                RX_START: begin
                    if (bit_cnt_q == CNT_HALF_END) begin
                        bit_cnt_q <= '0;
                        bit_idx_q <= 3'd0;
                        if (!rx_bit) begin
                            rx_state_q <= RX_DATA;
                        end else begin
                            // Line went high again: a glitch, not a start bit.
                            rx_state_q <= RX_IDLE;
                            busy_q     <= 1'b0;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        rx_data_q <= {rx_bit, rx_data_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (bit_end) begin
                        bit_cnt_q  <= '0;
                        rx_state_q <= RX_IDLE;
                        busy_q     <= 1'b0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    rx_state_q <= RX_IDLE;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Command parser
    // ------------------------------------------------------------------
    p_state_t        p_state_q;
    logic [5:0][3:0] shadow_q;
    logic [5:0][3:0] time_q;
    logic            load_q;
    logic            err_q;

    logic [2:0] dig_idx;
    logic [3:0] dig_max;
    p_state_t   dig_next;
    logic       is_digit;
    logic       digit_ok;

    // Which digit slot the current state fills, its upper bound, and the
    // state that follows an accepted digit.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        dig_idx  = 3'd0;
        dig_max  = 4'd9;
        dig_next = P_WAIT_CR;
        case (p_state_q)
            P_D0: begin dig_idx = 3'd0; dig_max = 4'd2; dig_next = P_D1; end
            P_D1: begin
                dig_idx  = 3'd1;
                // Hours 20-23 only: a leading 2 limits the second digit.
                dig_max  = (shadow_q[0] == 4'd2) ? 4'd3 : 4'd9;
                dig_next = P_D2;
            end
            P_D2: begin dig_idx = 3'd2; dig_max = 4'd5; dig_next = P_D3; end
            P_D3: begin dig_idx = 3'd3; dig_max = 4'd9; dig_next = P_D4; end
            P_D4: begin dig_idx = 3'd4; dig_max = 4'd5; dig_next = P_D5; end
            P_D5: begin dig_idx = 3'd5; dig_max = 4'd9; dig_next = P_WAIT_CR; end
            default: ;
        endcase
    end

    assign is_digit = (rx_data_q[7:4] == 4'h3) && (rx_data_q[3:0] <= 4'd9);
    assign digit_ok = is_digit && (rx_data_q[3:0] <= dig_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state_q <= P_WAIT_T;
            // NOTE: the shadow digits are a handful of flops that must read
            // zero after reset, so they are cleared here like any register
            // rather than treated as an unreset storage array.
            shadow_q  <= '0;
            time_q    <= '0;
            load_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            load_q <= 1'b0;
            err_q  <= 1'b0;
            if (frame_err) begin
                err_q     <= 1'b1;
                p_state_q <= P_WAIT_T;
            end else if (byte_done) begin
                if (rx_data_q == CH_T) begin
                    // 'T' always (re)starts a command, never an error.
                    p_state_q <= P_D0;
                end else begin
                    case (p_state_q)
                        P_WAIT_T: ;
                        P_WAIT_CR: begin
                            if (rx_data_q == CH_CR) begin
                                time_q <= shadow_q;
                                load_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                            p_state_q <= P_WAIT_T;
                        end
                        default: begin
                            if (digit_ok) begin
                                shadow_q[dig_idx] <= rx_data_q[3:0];
                                p_state_q         <= dig_next;
                            end else begin
                                err_q     <= 1'b1;
                                p_state_q <= P_WAIT_T;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign load       = load_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign hour_upper = time_q[0];
    assign hour_lower = time_q[1];
    assign min_upper  = time_q[2];
    assign min_lower  = time_q[3];
    assign sec_upper  = time_q[4];
    assign sec_lower  = time_q[5];

endmodule

// File: doc/time_set_rx.md
TIME_SET_RX -- requirements
Module: time_set_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; DIV = CLK_HZ/BAUD, truncated integer.
REQ-003 SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rxd  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 load  output  1  one-cycle pulse; the six BCD outputs hold a new valid time.
REQ-008 hour_upper, hour_lower, min_upper, min_lower, sec_upper, sec_lower  output  4 each  BCD time digits.
REQ-009 err  output  1  one-cycle pulse on framing error or invalid command byte.
REQ-010 busy  output  1  high while a UART frame is being received.

Function
REQ-011 SHALL pass rxd through a two-flop synchronizer before any use.
REQ-012 SHALL implement a receive FSM with states IDLE, START, DATA and STOP.
REQ-013 IDLE: a synchronized falling edge SHALL enter START, set busy=1 and clear the bit timer.
REQ-014 START: after DIV/2 cycles, rxd=0 SHALL enter DATA; rxd=1 SHALL return to IDLE (glitch) with no err and busy=0.
REQ-015 DATA: SHALL sample 8 bits, one every DIV cycles from the start-bit centre, LSB first.
REQ-016 STOP: SHALL sample DIV cycles after bit 7; 1 delivers the byte to the parser, 0 pulses err for one cycle and resets the parser to WAIT_T; both cases return to IDLE with busy=0.
REQ-017 SHALL implement a parser FSM with states WAIT_T, D0..D5 and WAIT_CR; command format is 'T'(0x54), six ASCII digits hhmmss, CR(0x0D).
REQ-018 WAIT_T: 0x54 SHALL advance to D0; any other byte SHALL be ignored silently.
REQ-019 In any state other than WAIT_T, byte 0x54 SHALL restart at D0 without err.
REQ-020 Digit checks: D0 (hour_upper) 0-2; D1 0-9, and 0-3 when D0=2; D2 (min_upper) 0-5; D3 0-9; D4 (sec_upper) 0-5; D5 0-9.
REQ-021 A byte outside 0x30-0x39, or a digit failing its range check, SHALL pulse err and go to WAIT_T.
REQ-022 SHALL store digits in internal shadow registers; outputs SHALL NOT change before load.
REQ-023 WAIT_CR: 0x0D SHALL copy the shadow digits to the outputs and assert load exactly 1 cycle after the stop-bit sample cycle, in the same cycle the outputs update; the parser then returns to WAIT_T.
REQ-024 WAIT_CR: any byte other than 0x0D or 0x54 SHALL pulse err and go to WAIT_T.
REQ-025 Outputs SHALL hold their values between load pulses.
REQ-026 load and err SHALL never be asserted in the same cycle.
REQ-027 Bit timer width SHALL be sized for DIV-1 without overflow.

Reset
REQ-028 rst SHALL force load=0, err=0, busy=0, all BCD outputs and shadow digits 0, synchronizer flops 1, receive FSM IDLE, parser WAIT_T.
REQ-029 rst mid-frame SHALL abort the frame with no load and no err.
REQ-030 The first falling edge after rst deasserts SHALL be treated as a new start bit.

Verification (CLK_HZ=1000000, BAUD=100000, DIV=10)
REQ-031 Send "T123456\r": one load pulse; outputs 1,2,3,4,5,6; err never asserted.
REQ-032 Send "T246000\r" after scenario 1: err pulse on the '4' byte; no load; outputs stay 12:34:56.
REQ-033 Send byte 0x54 with stop bit 0: err pulse at the stop sample; busy falls; the parser stays in WAIT_T (a following "123456\r" gives no load).
REQ-034 Drive rxd low for 3 cycles, then high: busy rises then falls within DIV/2+3 cycles; no err; no byte delivered.
REQ-035 Send "T12T235959\r": single load with outputs 2,3,5,9,5,9; no err.
REQ-036 Assert rst during bit 4 of 'T', then send "T000000\r": no load before the full frame; load with all zeros; busy=0 during rst.
